// File: rtl/ex04_07_pkg.sv
// Shared width and word type for the 4-bit two's-complementer.
package ex04_07_pkg;

  localparam int unsigned WORD_W = 4;

  typedef logic [WORD_W-1:0] word_t;

endpackage : ex04_07_pkg

// File: rtl/ex04_07_twos_comp4_comb.sv
// Combinational 4-bit two's complement: copy bits up to and including the
// first 1 from the LSB, invert every bit above it.
module twos_comp4_comb
  import ex04_07_pkg::*;
(
  input  word_t i,
  output word_t y
);

  // seen_one[k] is high when any bit below position k is set
  logic [WORD_W-1:0] seen_one;

  always_comb begin
    seen_one    = '0;
    seen_one[0] = 1'b0;
    for (int unsigned k = 1; k < WORD_W; k++) begin
      seen_one[k] = seen_one[k-1] | i[k-1];
    end
  end

  assign y = i ^ seen_one;

endmodule : twos_comp4_comb

// File: rtl/ex04_07.sv
// Registered 4-bit two's-complementer: {p,q,r,s} = -{i3,i2,i1,i0} mod 16,
// one clock after sampling, cleared asynchronously by rst_n.
module ex04_07
  import ex04_07_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  output logic p,
  output logic q,
  output logic r,
  output logic s
);

  word_t in_word;
  word_t neg_word;
  word_t res_q;

  assign in_word = {i3, i2, i1, i0};

  twos_comp4_comb u_comb (
    .i (in_word),
    .y (neg_word)
  );

  // Result register; carry out of the negation is simply not kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= neg_word;
    end
  end

  assign p = res_q[3];
  assign q = res_q[2];
  assign r = res_q[1];
  assign s = res_q[0];

endmodule : ex04_07

// File: tb/tb_ex04_07.sv
// Directed bench for ex04_07: vector table plus hand-written reset/glitch sequences.
module tb_ex04_07;

  logic clk;
  logic rst_n;
  logic i0, i1, i2, i3;
  logic p, q, r, s;
  logic [3:0] out_w;

  int total;
  int bad;

  typedef struct {
    logic [3:0] a;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[11];

  ex04_07 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .p     (p),
    .q     (q),
    .r     (r),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_w = {p, q, r, s};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] a);
    {i3, i2, i1, i0} = a;
  endtask

  // Apply at the falling edge, sample 1 time unit after the rising edge
  task automatic apply_and_sample(input logic [3:0] a);
    @(negedge clk);
    set_in(a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev_exp;
    logic [3:0] a;
    logic [3:0] e;

    total = 0;
    bad   = 0;

    vecs[0]  = '{4'b0001, 4'b1111};
    vecs[1]  = '{4'b0010, 4'b1110};
    vecs[2]  = '{4'b0100, 4'b1100};
    vecs[3]  = '{4'b1000, 4'b1000};
    vecs[4]  = '{4'b0000, 4'b0000};
    vecs[5]  = '{4'b1000, 4'b1000};
    vecs[6]  = '{4'b1111, 4'b0001};
    vecs[7]  = '{4'b0111, 4'b1001};
    vecs[8]  = '{4'b0101, 4'b1011};
    vecs[9]  = '{4'b1010, 4'b0110};
    vecs[10] = '{4'b0011, 4'b1101};

    // Reset held with all-ones input: outputs stay clear through clock edges
    rst_n = 1'b1;
    set_in(4'b1111);
    #2 rst_n = 1'b0;
    #1 check("reset_async", out_w, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("reset_held", out_w, 4'b0000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_pre_edge", out_w, 4'b0000);
    @(posedge clk);
    #1 check("reset_release_first", out_w, 4'b0001);

    // Table of directed vectors, including the one-hot sweep and wrap cases
    for (int k = 0; k < 11; k++) begin
      apply_and_sample(vecs[k].a);
      check($sformatf("vec%0d_%b", k, vecs[k].a), out_w, vecs[k].exp);
    end

    // Exhaustive back-to-back, also checking the previous result holds until the edge
    prev_exp = 4'b1101;
    for (int v = 0; v < 16; v++) begin
      a = 4'(v);
      e = 4'((16 - v) % 16);
      @(negedge clk);
      set_in(a);
      #1 check($sformatf("hold_before_%b", a), out_w, prev_exp);
      @(posedge clk);
      #1 check($sformatf("exh_%b", a), out_w, e);
      prev_exp = e;
    end

    // Mid-stream async reset while output shows 1110
    apply_and_sample(4'b0010);
    check("pre_midreset", out_w, 4'b1110);
    #1 rst_n = 1'b0;
    #1 check("midreset_async_clear", out_w, 4'b0000);
    set_in(4'b0011);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midreset_no_replay", out_w, 4'b0000);
    @(posedge clk);
    #1 check("midreset_resume", out_w, 4'b1101);

    // Glitch on i1 between edges; only the value at the edge matters
    @(negedge clk);
    set_in(4'b0100);
    #1 i1 = 1'b1;
    #1 check("glitch_invisible_mid", out_w, 4'b1101);
    #1 i1 = 1'b0;
    @(posedge clk);
    #1 check("glitch_sampled", out_w, 4'b1100);
    i1 = 1'b1;
    #1 i1 = 1'b0;
    #1 check("glitch_after_edge", out_w, 4'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ex04_07
